// File: rtl/key_debounce_edge_pkg.sv
// Shared definitions for the key debouncer: FSM state encodings and the
// default debounce length for a 50 MHz clock.
package key_debounce_edge_pkg;

  localparam int DEBOUNCE_CYCLES_50MHZ = 50000;

  localparam logic [1:0] ST_REL_STABLE = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_PRS_STABLE = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  typedef enum logic [1:0] {
    REL_STABLE = ST_REL_STABLE,
    PRESS_WAIT = ST_PRESS_WAIT,
    PRS_STABLE = ST_PRS_STABLE,
    REL_WAIT   = ST_REL_WAIT
  } state_t;

endpackage

// File: rtl/key_debounce_edge_timer.sv
// Debounce run-length timer: clears, counts consecutive new samples and flags
// the terminal count. It saturates at the terminal count instead of wrapping.
module key_debounce_edge_timer
  import key_debounce_edge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int TMR_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [TMR_W-1:0] TC = TMR_W'(DEBOUNCE_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmr <= '0;
    end else if (i_clr) begin
      r_tmr <= '0;
    end else if (i_inc && (r_tmr != TC)) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign o_tc = (r_tmr == TC);

endmodule

// File: rtl/key_debounce_edge.sv
// Debounces a synchronized key level into a clean active-high level, one-cycle
// press/release pulses and a wrapping press event counter.
module key_debounce_edge
  import key_debounce_edge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int TMR_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_in,
  input  logic             count_clr,
  output logic             pressed,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [EVT_W-1:0] press_count
);

  state_t           r_state;
  logic             r_pressed;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic [EVT_W-1:0] r_press_count;

  logic w_raw;
  logic w_tc;
  logic w_tmr_inc;
  logic w_tmr_clr;

  assign w_raw = sync_in ^ ACTIVE_LOW;

  // The timer counts only while a run of new samples continues; any other cycle restarts it at 0.
  always_comb begin
    w_tmr_inc = 1'b0;
    case (r_state)
      REL_STABLE: w_tmr_inc = w_raw;
      PRESS_WAIT: w_tmr_inc = w_raw && !w_tc;
      PRS_STABLE: w_tmr_inc = !w_raw;
      REL_WAIT:   w_tmr_inc = !w_raw && !w_tc;
      default:    w_tmr_inc = 1'b0;
    endcase
  end

  assign w_tmr_clr = !w_tmr_inc;

  key_debounce_edge_timer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TMR_W           (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tmr_clr),
    .i_inc   (w_tmr_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= REL_STABLE;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      case (r_state)
        REL_STABLE: begin
          if (w_raw) r_state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!w_raw) begin
            r_state <= REL_STABLE;
          end else if (w_tc) begin
            r_state       <= PRS_STABLE;
            r_pressed     <= 1'b1;
            r_press_pulse <= 1'b1;
          end
        end
        PRS_STABLE: begin
          if (!w_raw) r_state <= REL_WAIT;
        end
        REL_WAIT: begin
          if (w_raw) begin
            r_state <= PRS_STABLE;
          end else if (w_tc) begin
            r_state         <= REL_STABLE;
            r_pressed       <= 1'b0;
            r_release_pulse <= 1'b1;
          end
        end
        default: r_state <= REL_STABLE;
      endcase
    end
  end

  // A clear that coincides with a press pulse keeps that press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press_count <= '0;
    end else if (count_clr) begin
      r_press_count <= EVT_W'(r_press_pulse);
    end else if (r_press_pulse) begin
      r_press_count <= r_press_count + 1'b1;
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_count   = r_press_count;

endmodule
